// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: rebuilds pixel_x/pixel_y from hsync/vsync edges, checks line,
// hsync-width and frame timing, tracks lock and emits per-pixel data.
// Optional frame CRC-16-CCITT is enabled by defining VGA_RX_CRC_EN.
module vga_rx_monitor #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_TOTAL   = 525,
  parameter bit          SYNC_POL  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_tick,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [11:0] i_rgb,
  input  logic        i_err_clr,
  output logic [9:0]  o_pixel_x,
  output logic [9:0]  o_pixel_y,
  output logic        o_pixel_valid,
  output logic [11:0] o_rgb_q,
  output logic        o_locked,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_line_err,
  output logic        o_hsw_err,
  output logic        o_frame_err,
  output logic [15:0] o_frame_crc
);
  localparam logic [9:0] HLoad = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HLast = 10'(H_TOTAL - 1);
  localparam logic [9:0] HDisp = 10'(H_DISPLAY);
  localparam logic [9:0] HSync = 10'(H_SYNC);
  localparam logic [9:0] VLoad = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VLast = 10'(V_TOTAL - 1);
  localparam logic [9:0] VDisp = 10'(V_DISPLAY);

  typedef enum logic [1:0] {StHunt, StAcquire, StLocked} state_e;

  state_e      r_state;
  logic [1:0]  r_good;
  logic        r_err_since;
  logic        r_hs_prev, r_vs_prev, r_h_seen, r_v_seen;
  logic [9:0]  r_hcnt, r_vcnt, r_hs_run;
  logic [11:0] r_rgb;
  logic        r_pv, r_locked, r_fd;
  logic [15:0] r_fcnt;
  logic        r_line_err, r_hsw_err, r_frame_err;

  logic       w_hs, w_vs, w_hs_edge, w_hs_fall, w_vs_edge, w_h_wrap;
  logic [9:0] w_hcnt_free, w_vcnt_free, w_hcnt_d, w_vcnt_d;
  logic       w_checking, w_line_err, w_hsw_err, w_frame_err, w_err;
  logic       w_go_lock, w_locked_nx, w_pv_d, w_fd_d;

  // Sync decode and counter next-state for the current sample
  assign w_hs        = (i_hsync == SYNC_POL);
  assign w_vs        = (i_vsync == SYNC_POL);
  assign w_hs_edge   = w_hs && !r_hs_prev;
  assign w_hs_fall   = !w_hs && r_hs_prev;
  assign w_vs_edge   = w_vs && !r_vs_prev;
  assign w_hcnt_free = (r_hcnt == HLast) ? 10'd0 : r_hcnt + 10'd1;
  assign w_h_wrap    = r_h_seen && !w_hs_edge && (r_hcnt == HLast);
  assign w_vcnt_free = !w_h_wrap ? r_vcnt : ((r_vcnt == VLast) ? 10'd0 : r_vcnt + 10'd1);
  assign w_hcnt_d    = w_hs_edge ? HLoad : (r_h_seen ? w_hcnt_free : r_hcnt);
  assign w_vcnt_d    = w_vs_edge ? VLoad : (r_v_seen ? w_vcnt_free : r_vcnt);

  // Timing checks; line check needs a prior hs_edge so a held-at-0 hcnt is not judged
  assign w_checking  = (r_state != StHunt);
  assign w_line_err  = w_checking && w_hs_edge && r_h_seen && (w_hcnt_free != HLoad);
  assign w_hsw_err   = w_checking && w_hs_fall && (r_hs_run != HSync);
  assign w_frame_err = w_checking && w_vs_edge && (w_vcnt_free != VLoad);
  assign w_err       = w_line_err || w_hsw_err || w_frame_err;

  assign w_go_lock   = (r_state == StAcquire) && w_vs_edge && !w_err && !r_err_since &&
                       (r_good == 2'd1);
  assign w_locked_nx = ((r_state == StLocked) && !w_err) || w_go_lock;
  assign w_pv_d      = w_locked_nx && (w_hcnt_d < HDisp) && (w_vcnt_d < VDisp);
  assign w_fd_d      = w_pv_d && (w_hcnt_d == HDisp - 10'd1) && (w_vcnt_d == VDisp - 10'd1);

  // Per-sample pipeline: sync history, counters, hsync run length, pixel outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_h_seen  <= 1'b0;
      r_v_seen  <= 1'b0;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_hs_run  <= '0;
      r_rgb     <= '0;
      r_pv      <= 1'b0;
    end else if (i_pix_tick) begin
      r_hs_prev <= w_hs;
      r_vs_prev <= w_vs;
      r_h_seen  <= r_h_seen || w_hs_edge;
      r_v_seen  <= r_v_seen || w_vs_edge;
      r_hcnt    <= w_hcnt_d;
      r_vcnt    <= w_vcnt_d;
      r_rgb     <= i_rgb;
      r_pv      <= w_pv_d;
      if (w_hs) begin
        r_hs_run <= w_hs_edge ? 10'd1 : ((r_hs_run != '1) ? r_hs_run + 10'd1 : r_hs_run);
      end
    end
  end

  // Frame-done pulse (one clk) and frame counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_fd   <= 1'b0;
      r_fcnt <= '0;
    end else begin
      r_fd <= i_pix_tick && w_fd_d;
      if (i_pix_tick && w_fd_d) r_fcnt <= r_fcnt + 16'd1;
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_line_err  <= 1'b0;
      r_hsw_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_line_err  <= (i_pix_tick && w_line_err)  || (r_line_err  && !i_err_clr);
      r_hsw_err   <= (i_pix_tick && w_hsw_err)   || (r_hsw_err   && !i_err_clr);
      r_frame_err <= (i_pix_tick && w_frame_err) || (r_frame_err && !i_err_clr);
    end
  end

  // Lock FSM: good counts clean vs_edges; an error mid-frame spoils the next vs_edge
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= StHunt;
      r_good      <= '0;
      r_err_since <= 1'b0;
      r_locked    <= 1'b0;
    end else if (i_pix_tick) begin
      r_locked <= w_locked_nx;
      unique case (r_state)
        StHunt: begin
          if (w_vs_edge) begin
            r_state     <= StAcquire;
            r_good      <= '0;
            r_err_since <= 1'b0;
          end
        end
        StAcquire: begin
          if (w_vs_edge) begin
            r_err_since <= 1'b0;
            if (w_err || r_err_since) begin
              r_good <= '0;
            end else if (r_good == 2'd1) begin
              r_state <= StLocked;
              r_good  <= 2'd2;
            end else begin
              r_good <= r_good + 2'd1;
            end
          end else if (w_err) begin
            r_good      <= '0;
            r_err_since <= 1'b1;
          end
        end
        StLocked: begin
          if (w_err) begin
            r_state     <= StAcquire;
            r_good      <= '0;
            r_err_since <= !w_vs_edge;
          end
        end
        default: r_state <= StHunt;
      endcase
    end
  end

  assign o_pixel_x     = r_hcnt;
  assign o_pixel_y     = r_vcnt;
  assign o_pixel_valid = r_pv;
  assign o_rgb_q       = r_rgb;
  assign o_locked      = r_locked;
  assign o_frame_done  = r_fd;
  assign o_frame_cnt   = r_fcnt;
  assign o_line_err    = r_line_err;
  assign o_hsw_err     = r_hsw_err;
  assign o_frame_err   = r_frame_err;

`ifdef VGA_RX_CRC_EN
  logic [15:0] r_crc, r_frame_crc, w_crc_nx;
  logic        w_lock_loss;

  // CRC-16-CCITT over one 12-bit pixel, MSB first
  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] t;
    t = c;
    for (int i = 11; i >= 0; i--) begin
      t = (t[15] ^ d[i]) ? ((t << 1) ^ 16'h1021) : (t << 1);
    end
    return t;
  endfunction

  assign w_crc_nx    = crc_px(r_crc, i_rgb);
  assign w_lock_loss = (r_state == StLocked) && w_err;

  // Accumulate over valid pixels, restart per frame, latch at frame end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_crc       <= 16'hFFFF;
      r_frame_crc <= '0;
    end else if (i_pix_tick) begin
      if (w_vs_edge || w_lock_loss) begin
        r_crc <= 16'hFFFF;
      end else if (w_pv_d) begin
        r_crc <= w_crc_nx;
        if (w_fd_d) r_frame_crc <= w_crc_nx;
      end
    end
  end

  assign o_frame_crc = r_frame_crc;
`else
  assign o_frame_crc = '0;
`endif

endmodule

// File: doc/vga_rx_monitor.md
# vga_rx_monitor

Synthesizable receive-side companion to the pong display path. It consumes the `hsync`/`vsync`/`rgb` stream produced by the top-level VGA generator and reconstructs `pixel_x`/`pixel_y` from the sync edges alone. It checks line, sync-pulse and frame timing against 640x480 parameters and exposes per-pixel data with a lock indication. It sits beside the generator in loopback and self-check builds, and feeds frame-compare and on-chip status logic.

## Interface
- `H_DISPLAY`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width in pixel ticks
- `H_TOTAL`, 800, pixel ticks per line
- `V_DISPLAY`, 480, active lines per frame
- `V_FP`, 10, vertical front porch
- `V_TOTAL`, 525, lines per frame
- `SYNC_POL`, 1, asserted level of `hsync`/`vsync`
- `clk` in 1: system clock; all flops on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pix_tick` in 1: pixel-rate enable; inputs are sampled only when it is 1.
- `hsync` in 1: horizontal sync from the generator.
- `vsync` in 1: vertical sync from the generator.
- `rgb` in 12: pixel colour.
- `err_clr` in 1: clears the sticky error flags.
- `pixel_x` out 10: reconstructed column, 0..H_TOTAL-1.
- `pixel_y` out 10: reconstructed line, 0..V_TOTAL-1.
- `pixel_valid` out 1: locked and inside the active area.
- `rgb_q` out 12: sampled `rgb` aligned with `pixel_x`/`pixel_y`.
- `locked` out 1: high in state LOCKED.
- `frame_done` out 1: one-clk pulse after the last active pixel of a locked frame.
- `frame_cnt` out 16: count of `frame_done` pulses, wraps at 65535->0.
- `line_err` out 1: sticky flag.
- `hsw_err` out 1: sticky flag.
- `frame_err` out 1: sticky flag.
- `frame_crc` out 16: CRC of the last complete frame (see Configuration).

## Operation
- Each pix_tick sample registers `hsync`/`vsync` and keeps the previous samples.
- hs_edge: a sample is asserted (`== SYNC_POL`) and the previous sample was not. vs_edge is defined the same way for `vsync`.
- hcnt:
  - On hs_edge, hcnt loads `H_DISPLAY+H_FP` (656).
  - Otherwise it increments and wraps from `H_TOTAL-1` to 0.
- vcnt:
  - Increments when hcnt wraps and wraps from `V_TOTAL-1` to 0.
  - On vs_edge, it loads `V_DISPLAY+V_FP` (490). vs_edge has priority over the wrap increment.
- Before the first hs_edge after reset, hcnt holds 0. Before the first vs_edge, vcnt holds 0.
- Checks, evaluated only outside HUNT:
  - line_err sets when, at hs_edge, the free-running next hcnt is not 656.
  - hsw_err sets when the measured asserted run of `hsync` is not `H_SYNC` ticks. The run is measured at the deassertion edge.
  - frame_err sets when, at vs_edge, the free-running next vcnt is not 490.
- `err_clr` clears all three flags. If an error occurs in the same cycle, the set wins.
- Lock FSM:
  - HUNT -> ACQUIRE on the first vs_edge; good=0.
  - In ACQUIRE, each vs_edge with no error since the previous vs_edge increments good. Any error sets good=0.
  - ACQUIRE -> LOCKED when good reaches 2, i.e. on the third clean vs_edge after reset.
  - LOCKED -> ACQUIRE (good=0) on any error.
- `pixel_valid` = locked && hcnt<640 && vcnt<480.
- `frame_done` fires when `pixel_valid` is high and the sample is at (639,479).

## Timing
- Outputs are registered. `pixel_x`, `pixel_y`, `rgb_q`, `pixel_valid` and `frame_done` are updated at the clk edge on which `pix_tick`=1. They reflect the sample taken at that same edge, so latency is 1 clk from the sample edge, with values visible in the next cycle.
- `pixel_x` for the sample carrying hs_edge reads 656. `pixel_y` for the sample carrying vs_edge reads 490.
- `frame_done` is exactly one clk wide. `frame_cnt` increments in the same clk.
- Error flags assert 1 clk after the offending sample.
- `locked` changes in the same clk as the deciding vs_edge sample is registered.
- Outputs hold when `pix_tick`=0, except `frame_done`, which returns to 0.
- Reset values: `pixel_x`=0, `pixel_y`=0, `rgb_q`=0, `pixel_valid`=0, `locked`=0, `frame_done`=0, `frame_cnt`=0, all error flags 0, `frame_crc`=0. The FSM goes to HUNT.
- Previous sync samples reset to the deasserted level, so a sync already asserted at reset release counts as an edge.
- Reset asserted mid-frame aborts immediately. Relock needs three clean vs_edges.

## Configuration
- Macro `VGA_RX_CRC_EN`.
- Defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF) is accumulated over `rgb_q` (MSB first, 12 bits per pixel) on every `pixel_valid` sample.
  - `frame_crc` latches the final value in the `frame_done` clk.
  - The accumulator reinitialises to 0xFFFF at every vs_edge and on any lock loss.
- Undefined: `frame_crc` is constant 0 and no CRC logic is synthesised.

## Test plan
- Reference 640x480 generator from reset, `pix_tick` every 4 clk -> `locked`=1 at the third vsync leading edge. `frame_done` pulses once per 420000 ticks, `frame_cnt` increments by 1 per frame, all error flags stay 0.
- Locked; one line shortened to 799 ticks -> `line_err`=1 at the next hs_edge, `locked` drops, then relock after 2 further clean frames. Pulse `err_clr` -> flags 0.
- Locked; one hsync pulse widened to 97 ticks -> `hsw_err`=1 and `locked`=0. `frame_err` stays 0.
- Frame with 524 lines -> `frame_err`=1 at the early vs_edge; `pixel_y` reads 490 for that sample.
- `rst` low at pixel (300,200) for 3 clk -> all outputs at reset values, FSM in HUNT. `locked` returns after 3 clean vs_edges.
- With `VGA_RX_CRC_EN`, constant `rgb`=12'h0F0 frame -> `frame_crc` equals the bench model CRC of 307200 pixels and is identical on consecutive frames. Without the macro -> `frame_crc`=0.
